// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared types and constants for the forwarding scoreboard.
//               sb_entry_t describes one in-flight writer in the shadow
//               pipeline. Its rd/lat fields use fixed maximum widths, so
//               scoreboard instances must keep AW <= SB_AW_MAX and
//               LW <= SB_LW_MAX. Narrower values are zero-extended.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  localparam int SB_AW_MAX = 8;
  localparam int SB_LW_MAX = 8;

  // One shadow-pipeline slot.
  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [SB_AW_MAX-1:0] rd;
    logic [SB_LW_MAX-1:0] lat;
  } sb_entry_t;

  localparam logic [SB_LW_MAX-1:0] LAT_ALU  = SB_LW_MAX'(1);
  localparam logic [SB_LW_MAX-1:0] LAT_LOAD = SB_LW_MAX'(2);
  localparam int                   FWD_RF   = 0;
  localparam sb_entry_t            SB_BUBBLE = '0;

  // x0 is hard-wired, so writes to it never produce a bypassable value.
  function automatic logic is_producer(input sb_entry_t e,
                                       input logic [SB_AW_MAX-1:0] r);
    return e.valid && e.we && (e.rd != '0) && (e.rd == r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_src_match.sv
`default_nettype none
// ============================================================================
// Module      : fwd_src_match
// Description : Bypass lookup for one source operand. Finds the youngest
//               in-flight producer of rs and reports either a bypass select
//               (its stage position next cycle) or a hazard when that
//               producer's result will not yet be available.
// Ports       : sb     - shadow pipeline, sb[0] = instruction in EX
//               rs     - source register address
//               used   - source is actually read
//               sel    - bypass select (0 = register file)
//               hazard - youngest producer not forwardable, ID must stall
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  parameter int SW    = $clog2(DEPTH+1)
) (
  input  sb_entry_t [DEPTH-1:0] sb,
  input  logic      [AW-1:0]    rs,
  input  logic                  used,
  output logic      [SW-1:0]    sel,
  output logic                  hazard
);

  logic [DEPTH-1:0] w_hit;
  logic [DEPTH-1:0] w_ok;
  logic             w_found;
  logic             w_fwd;
  logic [SW-1:0]    w_sel;

  // Entry g will sit at bypass stage g+1 next cycle. lat <= g+1 also covers
  // lat = 0 (treated as 1) and excludes lat > DEPTH, since g+1 <= DEPTH.
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      assign w_hit[g] = is_producer(sb[g], SB_AW_MAX'(rs));
      assign w_ok[g]  = (sb[g].lat <= SB_LW_MAX'(g + 1));
    end
  endgenerate

  // Scan oldest to youngest so the youngest hit wins; an older forwardable
  // copy therefore never masks a younger stalling one.
  always_comb begin
    w_found = 1'b0;
    w_fwd   = 1'b0;
    w_sel   = SW'(FWD_RF);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_found = 1'b1;
        w_fwd   = w_ok[i];
        w_sel   = SW'(i + 1);
      end
    end
  end

  assign hazard = used & w_found & ~w_fwd;
  assign sel    = (used & w_found & w_fwd) ? w_sel : SW'(FWD_RF);

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard
// Description : Bypass/hazard scoreboard for the in-order integer pipeline.
//               Keeps a shadow pipeline of in-flight writers behind EX,
//               raises a combinational stall for ID when a source's youngest
//               producer is not yet bypassable, and registers per-operand
//               bypass selects for the instruction entering EX.
// Ports       : clk, rst_n          - clock, async active-low reset
//               id_valid/id_rs/id_rs_used/id_rd/id_we/id_lat - ID instruction
//               hold               - pipeline-wide freeze
//               flush              - kill the ID instruction
//               stall              - ID must not advance (combinational)
//               ex_fwd_sel         - registered bypass selects for EX
//               perf_stall_cnt     - saturating stall-cycle counter
// Config      : define FWD_STALL_CNT_EN to build the stall counter;
//               otherwise perf_stall_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH+2),
  parameter int SW    = $clog2(DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [NSRC-1:0][AW-1:0]    id_rs,
  input  logic [NSRC-1:0]            id_rs_used,
  input  logic [AW-1:0]              id_rd,
  input  logic                       id_we,
  input  logic [LW-1:0]              id_lat,
  input  logic                       hold,
  input  logic                       flush,
  output logic                       stall,
  output logic [NSRC-1:0][SW-1:0]    ex_fwd_sel,
  output logic [31:0]                perf_stall_cnt
);

  sb_entry_t [DEPTH-1:0]      r_sb;
  logic [NSRC-1:0][SW-1:0]    r_sel;
  logic [NSRC-1:0][SW-1:0]    w_sel;
  logic [NSRC-1:0]            w_hazard;
  sb_entry_t                  w_id_entry;

  generate
    for (genvar g = 0; g < NSRC; g++) begin : g_src
      fwd_src_match #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .SW    (SW)
      ) u_match (
        .sb     (r_sb),
        .rs     (id_rs[g]),
        .used   (id_rs_used[g]),
        .sel    (w_sel[g]),
        .hazard (w_hazard[g])
      );
    end
  endgenerate

  // Depends only on registered state and ID inputs, never on hold/flush.
  assign stall = id_valid & (|w_hazard);

  always_comb begin
    w_id_entry       = SB_BUBBLE;
    w_id_entry.valid = id_valid;
    w_id_entry.we    = id_we;
    w_id_entry.rd    = SB_AW_MAX'(id_rd);
    w_id_entry.lat   = SB_LW_MAX'(id_lat);
  end

  // hold freezes everything; flush and stall both inject a bubble into EX
  // while older writers keep draining, so the stalled instruction sees
  // its producer move one stage further each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb  <= '0;
      r_sel <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_sb[k] <= r_sb[k-1];
      end
      if (flush || stall) begin
        r_sb[0] <= SB_BUBBLE;
        r_sel   <= '0;
      end else begin
        r_sb[0] <= w_id_entry;
        r_sel   <= w_sel;
      end
    end
  end

  assign ex_fwd_sel = r_sel;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall && !hold && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_scoreboard
// Description : Directed scoreboard bench for fwd_scoreboard (DEPTH = 2,
//               NSRC = 2). Each stimulus row pushes its expected stall,
//               bypass selects and stall count; a monitor pops and compares
//               on every falling edge. Honours FWD_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;

  localparam int AW    = 5;
  localparam int NSRC  = 2;
  localparam int DEPTH = 2;
  localparam int LW    = 2;
  localparam int SW    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    id_valid;
  logic [NSRC-1:0][AW-1:0] id_rs;
  logic [NSRC-1:0]         id_rs_used;
  logic [AW-1:0]           id_rd;
  logic                    id_we;
  logic [LW-1:0]           id_lat;
  logic                    hold;
  logic                    flush;
  logic                    stall;
  logic [NSRC-1:0][SW-1:0] ex_fwd_sel;
  logic [31:0]             perf_stall_cnt;

  fwd_scoreboard #(
    .AW    (AW),
    .NSRC  (NSRC),
    .DEPTH (DEPTH),
    .LW    (LW),
    .SW    (SW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rs_used     (id_rs_used),
    .id_rd          (id_rd),
    .id_we          (id_we),
    .id_lat         (id_lat),
    .hold           (hold),
    .flush          (flush),
    .stall          (stall),
    .ex_fwd_sel     (ex_fwd_sel),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  string       q_nm[$];
  logic        q_stall[$];
  logic [3:0]  q_sel[$];
  logic [31:0] q_cnt[$];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt = '0;

  // Monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    string       nm;
    logic        es;
    logic [3:0]  esel;
    logic [31:0] ecnt;
    if (q_nm.size() > 0) begin
      nm   = q_nm.pop_front();
      es   = q_stall.pop_front();
      esel = q_sel.pop_front();
      ecnt = q_cnt.pop_front();
      total++;
      if (stall !== es) begin
        bad++;
        $display("FAIL %s stall: got %0b want %0b", nm, stall, es);
      end
      total++;
      if (ex_fwd_sel !== esel) begin
        bad++;
        $display("FAIL %s ex_fwd_sel{1,0}: got %0d,%0d want %0d,%0d", nm,
                 ex_fwd_sel[1], ex_fwd_sel[0], esel[3:2], esel[1:0]);
      end
      total++;
      if (perf_stall_cnt !== ecnt) begin
        bad++;
        $display("FAIL %s perf_stall_cnt: got %0d want %0d", nm, perf_stall_cnt, ecnt);
      end
    end
  end

  // Drive one ID cycle and queue what must be seen during it.
  // e0/e1 are the expected selects for source 0 (rs1) and source 1 (rs2).
  task automatic step(input string nm, input logic r, v,
                      input logic [4:0] rs1, rs2, input logic [1:0] used,
                      input logic [4:0] rd, input logic we, input logic [1:0] lat,
                      input logic hd, fl, es, input logic [1:0] e0, e1);
    rst_n         = r;
    id_valid      = v;
    id_rs[0]      = rs1;
    id_rs[1]      = rs2;
    id_rs_used    = used;
    id_rd         = rd;
    id_we         = we;
    id_lat        = lat;
    hold          = hd;
    flush         = fl;
`ifdef FWD_STALL_CNT_EN
    if (!r) exp_cnt = '0;
`endif
    q_nm.push_back(nm);
    q_stall.push_back(es);
    q_sel.push_back({e1, e0});
    q_cnt.push_back(exp_cnt);
    @(posedge clk);
    #1;
`ifdef FWD_STALL_CNT_EN
    if (r && es && !hd && !fl) exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rs_used = '0;
    id_rd = '0; id_we = 1'b0; id_lat = '0; hold = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //    name              rst v rs1 rs2 used  rd we lat hd fl st e0 e1
    step("reset",           0, 1, 5,  5,  2'b11, 5, 1, 2, 0, 0, 0, 0, 0);
    // ALU x5 then consumer of x5
    step("alu_x5",          1, 1, 0,  0,  2'b00, 5, 1, 1, 0, 0, 0, 0, 0);
    step("use_x5",          1, 1, 5,  0,  2'b01, 6, 1, 1, 0, 0, 0, 0, 0);
    step("alu_sel",         1, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    // load-use on rs2
    step("ld_x7",           1, 1, 0,  0,  2'b00, 7, 1, 2, 0, 0, 0, 0, 0);
    step("ld_use_stall",    1, 1, 1,  7,  2'b10, 8, 1, 1, 0, 0, 1, 0, 0);
    step("ld_use_go",       1, 1, 1,  7,  2'b10, 8, 1, 1, 0, 0, 0, 0, 0);
    step("ld_sel",          1, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 2);
    // two writers of x3, then a write to x0 read back as x0
    step("wr_x3_a",         1, 1, 0,  0,  2'b00, 3, 1, 1, 0, 0, 0, 0, 0);
    step("wr_x3_b",         1, 1, 0,  0,  2'b00, 3, 1, 1, 0, 0, 0, 0, 0);
    step("use_x3",          1, 1, 3,  3,  2'b11, 0, 1, 2, 0, 0, 0, 0, 0);
    step("use_x0",          1, 1, 0,  0,  2'b11, 9, 0, 1, 0, 0, 0, 1, 1);
    step("x0_sel",          1, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // older ALU x4 must not hide younger load x4
    step("alu_x4",          1, 1, 0,  0,  2'b00, 4, 1, 1, 0, 0, 0, 0, 0);
    step("ld_x4",           1, 1, 0,  0,  2'b00, 4, 1, 2, 0, 0, 0, 0, 0);
    step("young_ld_stall",  1, 1, 4,  0,  2'b01, 0, 0, 1, 0, 0, 1, 0, 0);
    step("young_ld_go",     1, 1, 4,  0,  2'b01, 0, 0, 1, 0, 0, 0, 0, 0);
    step("young_sel",       1, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 2, 0);
    // lat = DEPTH+1 producer: stalls until it leaves, then register file
    step("lat3_x10",        1, 1, 0,  0,  2'b00, 10, 1, 3, 0, 0, 0, 0, 0);
    step("lat3_stall1",     1, 1, 10, 0,  2'b01, 11, 1, 1, 0, 0, 1, 0, 0);
    step("lat3_stall2",     1, 1, 10, 0,  2'b01, 11, 1, 1, 0, 0, 1, 0, 0);
    step("lat3_go",         1, 1, 10, 0,  2'b01, 11, 1, 1, 0, 0, 0, 0, 0);
    step("lat3_rf",         1, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // load x12 (forwarding x11 from stage 2), hold during load-use, then flush
    step("ld_x12",          1, 1, 11, 0,  2'b01, 12, 1, 2, 0, 0, 0, 0, 0);
    step("hold_stall1",     1, 1, 0,  12, 2'b10, 13, 1, 1, 1, 0, 1, 2, 0);
    step("hold_stall2",     1, 1, 0,  12, 2'b10, 13, 1, 1, 1, 0, 1, 2, 0);
    step("flush",           1, 1, 0,  12, 2'b10, 13, 1, 1, 0, 1, 1, 2, 0);
    step("flush_sel",       1, 1, 0,  12, 2'b10, 13, 1, 1, 0, 0, 0, 0, 0);
    step("post_flush_sel",  1, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 2);
    // reset in the middle of a load-use stall
    step("ld_x14",          1, 1, 0,  0,  2'b00, 14, 1, 2, 0, 0, 0, 0, 0);
    step("pre_rst_stall",   1, 1, 14, 0,  2'b01, 0, 0, 1, 0, 0, 1, 0, 0);
    step("rst_mid",         0, 1, 14, 0,  2'b01, 0, 0, 1, 0, 0, 0, 0, 0);
    step("post_rst",        1, 1, 14, 0,  2'b01, 0, 0, 1, 0, 0, 0, 0, 0);
    // three counted stall cycles after reset
    step("ld_x16",          1, 1, 0,  0,  2'b00, 16, 1, 2, 0, 0, 0, 0, 0);
    step("cnt_stall1",      1, 1, 16, 0,  2'b01, 0, 0, 1, 0, 0, 1, 0, 0);
    step("cnt_go1",         1, 1, 16, 0,  2'b01, 0, 0, 1, 0, 0, 0, 0, 0);
    step("lat3_x17",        1, 1, 0,  0,  2'b00, 17, 1, 3, 0, 0, 0, 2, 0);
    step("cnt_stall2",      1, 1, 17, 0,  2'b01, 0, 0, 1, 0, 0, 1, 0, 0);
    step("cnt_stall3",      1, 1, 17, 0,  2'b01, 0, 0, 1, 0, 0, 1, 0, 0);
    step("cnt_go2",         1, 1, 17, 0,  2'b01, 0, 0, 1, 0, 0, 0, 0, 0);
    step("cnt_final",       1, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    total++;
    if (q_nm.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q_nm.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised bypass/hazard scoreboard for the in-order integer pipeline. It replaces the purely combinational EX-stage forwarding compare with a shadow pipeline of in-flight writers. It tracks each writer's destination and result latency, and uses them to:
- raise a load-use (or any multi-cycle) stall for the instruction in ID;
- register per-operand bypass selects into EX, for any number of source operands and bypass stages.

## Interface
Parameters:
- AW, 5, register-address width
- NSRC, 2, number of source operands per instruction
- DEPTH, 2, number of bypass stages after EX (1 = EX/MEM, 2 = MEM/WB, …)
- LW, $clog2(DEPTH+2), width of latency field
- SW, $clog2(DEPTH+1), width of one forward select

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- id_valid  in  1  valid instruction in ID
- id_rs  in  [NSRC][AW]  source register addresses of the ID instruction
- id_rs_used  in  NSRC  source k is actually read
- id_rd  in  AW  destination register
- id_we  in  1  ID instruction writes the register file
- id_lat  in  LW  cycles after entering EX until the result is bypassable (ALU 1, load 2)
- hold  in  1  pipeline-wide freeze
- flush  in  1  kill the ID instruction
- stall  out  1  ID must not advance (combinational)
- ex_fwd_sel  out  [NSRC][SW]  registered bypass select for the instruction now in EX
- perf_stall_cnt  out  32  stall-cycle counter (only with FWD_STALL_CNT_EN)

## Operation
- **Shadow pipeline.** Entries sb[0..DEPTH-1]; sb[0] is the instruction in EX, sb[k] is k stages past EX. Each entry holds {valid, we, rd, lat}.
- **Producer qualification.** An entry is a producer of register r iff valid & we & rd != 0 & rd == r.
- **Per-source lookup.** For each source k with id_rs_used[k], find the youngest producer (lowest index i).
  - The candidate select is i+1, i.e. its position next cycle.
  - It is forwardable iff i+1 >= max(id-side lat of that entry, 1).
  - Entries with lat > DEPTH are never forwardable.
  - With no producer found, the select is 0 (register file, write-before-read).
- **Stall.** stall = id_valid & (some used source's youngest producer is not forwardable). An older forwardable match never hides a younger non-forwardable one.
- **Select encoding.** 0 = register file; n = bypass stage n (1 = EX/MEM, 2 = MEM/WB).
- **Update priority per clock edge: hold > flush > stall > advance.**
  - **hold:** all state frozen, ex_fwd_sel held.
  - **flush:** sb[0] <= bubble, sb[k] <= sb[k-1], ex_fwd_sel <= 0.
  - **stall:** same as flush (bubble into EX); the ID instruction is re-evaluated next cycle.
  - **advance:** sb[0] <= {id_valid, id_we, id_rd, id_lat}, sb[k] <= sb[k-1], ex_fwd_sel <= computed selects. Unused sources get 0.
- sb[DEPTH-1] drops out on shift. Its result is then in the register file.

## Timing
- **Reset:** all sb entries invalid, ex_fwd_sel = 0, perf_stall_cnt = 0; stall = 0 until a hazard exists.
- stall is valid in the same cycle as the ID inputs. It is derived from registered state plus ID inputs only, with no combinational path from hold or flush.
- ex_fwd_sel is valid one cycle after the ID instruction advances, aligned with that instruction in EX.
- **Load-use (lat 2) followed immediately by a consumer:** exactly 1 stall cycle, then select 2.
- A lat = L producer directly ahead stalls the consumer for L-1 cycles.
- Reset mid-operation clears the scoreboard; in-flight hazards are forgotten.

## Configuration
- **FWD_STALL_CNT_EN defined:** perf_stall_cnt increments every cycle with stall & ~hold & ~flush, and saturates at 2^32-1.
- **Not defined:** the port is still present and tied to 0; no counter flops are synthesised.

## Structure
- **fwd_pkg:** typedef sb_entry_t {valid, we, rd, lat}; constants LAT_ALU = 1, LAT_LOAD = 2; FWD_RF = 0.
- **Sub-module fwd_src_match:** one instance per source. It takes the sb array and rs/used, and returns {sel, hazard}. Priority search over DEPTH entries.

## Test plan
- ALU x5 then consumer rs1 = x5 (lat 1) → stall = 0; next cycle ex_fwd_sel[0] = 1, ex_fwd_sel[1] = 0.
- Load x7 (lat 2) then consumer rs2 = x7 → stall = 1 for one cycle, EX bubble with sel 0; then ex_fwd_sel[1] = 2.
- Writers x3 at sb[1] and sb[0], consumer rs1 = rs2 = x3 → both selects = 1 (youngest); write to x0 with rs = x0 → sel 0, no stall.
- Producer with lat = DEPTH+1 → consumer stalls until the entry exits sb[DEPTH-1], then sel = 0.
- hold during a load-use stall → sb and ex_fwd_sel frozen, stall stays 1. flush → bubble, sel 0, counter does not increment.
- rst_n low mid-stall → ex_fwd_sel = 0, stall = 0 immediately. With FWD_STALL_CNT_EN, 3 stall cycles → perf_stall_cnt = 3.
